// File: rtl/decode_queue.sv
// MIPS32 decode stage: DEPTH-entry instruction FIFO feeding a registered decoded record; 2-edge latency, 1/cycle.
// in_ready depends only on FIFO occupancy and flush; a stalled record holds while the FIFO keeps filling.
module decode_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int EXT_OPS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [13:0]            out_op,
    output logic [4:0]             out_rs,
    output logic [4:0]             out_rt,
    output logic [4:0]             out_rd,
    output logic                   out_rs_valid,
    output logic                   out_rt_valid,
    output logic                   out_rd_valid,
    output logic [5:0]             out_funct,
    output logic [31:0]            out_imm32,
    output logic [25:0]            out_jtarget,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam bit EXT = (EXT_OPS != 0);

    localparam int OP_ALU   = 0;
    localparam int OP_ORI   = 1;
    localparam int OP_LUI   = 2;
    localparam int OP_LW    = 3;
    localparam int OP_SW    = 4;
    localparam int OP_BEQ   = 5;
    localparam int OP_J     = 6;
    localparam int OP_JAL   = 7;
    localparam int OP_JR    = 8;
    localparam int OP_SYS   = 9;
    localparam int OP_ADDIU = 10;
    localparam int OP_BNE   = 11;
    localparam int OP_SLT   = 12;
    localparam int OP_JALR  = 13;

    // Which op flags make each field meaningful
    localparam logic [13:0] RS_MASK    = 14'h3D3B;
    localparam logic [13:0] RT_MASK    = 14'h1C3F;
    localparam logic [13:0] RD_MASK    = 14'h3001;
    localparam logic [13:0] RTYPE_MASK = 14'h3301;
    localparam logic [13:0] SEXT_MASK  = 14'h0C38;

    logic [31:0]     mem_instr [DEPTH];
    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    logic [31:0]     head;
    logic [PC_W-1:0] head_pc;

    logic [13:0] d_op;
    logic        d_rs_v, d_rt_v, d_rd_v;
    logic [4:0]  d_rs, d_rt, d_rd;
    logic [5:0]  d_funct;
    logic [31:0] d_imm;
    logic [25:0] d_jt;

    assign in_ready = (count < FULL) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && (!out_valid || out_ready) && !flush;
    assign head     = mem_instr[rd_ptr];
    assign head_pc  = mem_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_comb begin
        d_op = '0;
        if (head[31:26] == 6'h00) begin
            case (head[5:0])
                6'h21, 6'h23: d_op[OP_ALU]  = 1'b1;
                6'h08:        d_op[OP_JR]   = 1'b1;
                6'h0c:        d_op[OP_SYS]  = 1'b1;
                6'h2a:        d_op[OP_SLT]  = EXT;
                6'h09:        d_op[OP_JALR] = EXT;
                default:      d_op = '0;
            endcase
        end else begin
            case (head[31:26])
                6'h0d:   d_op[OP_ORI]   = 1'b1;
                6'h0f:   d_op[OP_LUI]   = 1'b1;
                6'h23:   d_op[OP_LW]    = 1'b1;
                6'h2b:   d_op[OP_SW]    = 1'b1;
                6'h04:   d_op[OP_BEQ]   = 1'b1;
                6'h02:   d_op[OP_J]     = 1'b1;
                6'h03:   d_op[OP_JAL]   = 1'b1;
                6'h05:   d_op[OP_BNE]   = EXT;
                6'h09:   d_op[OP_ADDIU] = EXT;
                default: d_op = '0;
            endcase
        end

        d_rs_v  = |(d_op & RS_MASK);
        d_rt_v  = |(d_op & RT_MASK);
        d_rd_v  = |(d_op & RD_MASK);
        d_rs    = d_rs_v ? head[25:21] : 5'd0;
        d_rt    = d_rt_v ? head[20:16] : 5'd0;
        d_rd    = d_rd_v ? head[15:11] : 5'd0;
        d_funct = (|(d_op & RTYPE_MASK)) ? head[5:0] : 6'd0;
        d_jt    = (d_op[OP_J] || d_op[OP_JAL]) ? head[25:0] : 26'd0;

        d_imm = '0;
        if (|(d_op & SEXT_MASK)) d_imm = {{16{head[15]}}, head[15:0]};
        else if (d_op[OP_ORI])   d_imm = {16'h0, head[15:0]};
        else if (d_op[OP_LUI])   d_imm = {head[15:0], 16'h0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_op       <= '0;
            out_rs       <= '0;
            out_rt       <= '0;
            out_rd       <= '0;
            out_rs_valid <= 1'b0;
            out_rt_valid <= 1'b0;
            out_rd_valid <= 1'b0;
            out_funct    <= '0;
            out_imm32    <= '0;
            out_jtarget  <= '0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid    <= 1'b1;
            out_pc       <= head_pc;
            out_op       <= d_op;
            out_rs       <= d_rs;
            out_rt       <= d_rt;
            out_rd       <= d_rd;
            out_rs_valid <= d_rs_v;
            out_rt_valid <= d_rt_v;
            out_rd_valid <= d_rd_v;
            out_funct    <= d_funct;
            out_imm32    <= d_imm;
            out_jtarget  <= d_jt;
            out_illegal  <= (d_op == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (extensions on/off) sharing stimulus, checked against a queue model.
module tb_decode_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [13:0] op;
        logic [4:0]  rs, rt, rd;
        logic        rsv, rtv, rdv;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [25:0] jt;
        logic        ill;
    } rec_t;

    logic clk, rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready_a, out_valid_a, rsv_a, rtv_a, rdv_a, ill_a;
    logic [31:0] pc_a, imm_a;
    logic [13:0] op_a;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic [5:0]  funct_a;
    logic [25:0] jt_a;
    logic [2:0]  count_a;

    logic        in_ready_b, out_valid_b, rsv_b, rtv_b, rdv_b, ill_b;
    logic [31:0] pc_b, imm_b;
    logic [13:0] op_b;
    logic [4:0]  rs_b, rt_b, rd_b;
    logic [5:0]  funct_b;
    logic [25:0] jt_b;
    logic [2:0]  count_b;

    rec_t act_a, act_b;
    assign act_a = {pc_a, op_a, rs_a, rt_a, rd_a, rsv_a, rtv_a, rdv_a, funct_a, imm_a, jt_a, ill_a};
    assign act_b = {pc_b, op_b, rs_b, rt_b, rd_b, rsv_b, rtv_b, rdv_b, funct_b, imm_b, jt_b, ill_b};

    decode_queue #(.DEPTH(DEPTH), .PC_W(32), .EXT_OPS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_pc(pc_a), .out_op(op_a), .out_rs(rs_a), .out_rt(rt_a), .out_rd(rd_a),
        .out_rs_valid(rsv_a), .out_rt_valid(rtv_a), .out_rd_valid(rdv_a), .out_funct(funct_a),
        .out_imm32(imm_a), .out_jtarget(jt_a), .out_illegal(ill_a), .count(count_a));

    decode_queue #(.DEPTH(DEPTH), .PC_W(32), .EXT_OPS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_pc(pc_b), .out_op(op_b), .out_rs(rs_b), .out_rt(rt_b), .out_rd(rd_b),
        .out_rs_valid(rsv_b), .out_rt_valid(rtv_b), .out_rd_valid(rdv_b), .out_funct(funct_b),
        .out_imm32(imm_b), .out_jtarget(jt_b), .out_illegal(ill_b), .count(count_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: list of accepted {pc, instr} plus the one output slot
    logic [63:0] mq[$];
    bit          m_vld;
    logic [63:0] m_out;

    function automatic rec_t ref_decode(input logic [31:0] pc, input logic [31:0] w, input bit ext);
        rec_t r;
        int k;
        r = '0;
        r.pc = pc;
        k = -1;
        if (w[31:26] == 6'h00) begin
            case (w[5:0])
                6'h21, 6'h23: k = 0;
                6'h08: k = 8;
                6'h0c: k = 9;
                6'h2a: if (ext) k = 12;
                6'h09: if (ext) k = 13;
                default: k = -1;
            endcase
        end else begin
            case (w[31:26])
                6'h0d: k = 1;
                6'h0f: k = 2;
                6'h23: k = 3;
                6'h2b: k = 4;
                6'h04: k = 5;
                6'h02: k = 6;
                6'h03: k = 7;
                6'h05: if (ext) k = 11;
                6'h09: if (ext) k = 10;
                default: k = -1;
            endcase
        end
        if (k < 0) begin
            r.ill = 1'b1;
            return r;
        end
        r.op[k] = 1'b1;
        case (k)
            0, 12: begin
                r.rs = w[25:21]; r.rsv = 1'b1; r.rt = w[20:16]; r.rtv = 1'b1;
                r.rd = w[15:11]; r.rdv = 1'b1; r.funct = w[5:0];
            end
            8:  begin r.rs = w[25:21]; r.rsv = 1'b1; r.funct = w[5:0]; end
            9:  r.funct = w[5:0];
            13: begin r.rs = w[25:21]; r.rsv = 1'b1; r.rd = w[15:11]; r.rdv = 1'b1; r.funct = w[5:0]; end
            1:  begin r.rs = w[25:21]; r.rsv = 1'b1; r.rt = w[20:16]; r.rtv = 1'b1; r.imm = {16'h0, w[15:0]}; end
            2:  begin r.rt = w[20:16]; r.rtv = 1'b1; r.imm = {w[15:0], 16'h0}; end
            6, 7: r.jt = w[25:0];
            default: begin
                r.rs = w[25:21]; r.rsv = 1'b1; r.rt = w[20:16]; r.rtv = 1'b1;
                r.imm = {{16{w[15]}}, w[15:0]};
            end
        endcase
        return r;
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit ordy, input bit fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        bit acc, pop;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_vld = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            pop = (mq.size() > 0) && (!m_vld || out_ready);
            if (pop) begin
                m_out = mq.pop_front();
                m_vld = 1'b1;
            end else if (out_ready) begin
                m_vld = 1'b0;
            end
            if (acc) mq.push_back({in_pc, in_instr});
        end
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if (out_valid_a !== 1'b0 || count_a !== 3'd0 || in_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ctrl: got vld=%b cnt=%0d rdy=%b want 0 0 1", out_valid_a, count_a, in_ready_a);
        end
        vectors++;
        if (act_a !== '0 || act_b !== '0) begin
            miscompares++;
            $display("FAIL reset_fields: got %h / %h want 0", act_a, act_b);
        end
    endtask

    task automatic test_addu();
        drive(1, 32'h00221821, 32'h100, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        vectors++;
        if (out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL addu_no_bypass: got out_valid=%b want 0", out_valid_a);
        end
        tick();
        vectors++;
        if (out_valid_a !== 1'b1 || act_a.op !== 14'h0001 || act_a.pc !== 32'h100) begin
            miscompares++;
            $display("FAIL addu_op: got vld=%b op=%h pc=%h want 1 0001 100", out_valid_a, act_a.op, act_a.pc);
        end
        vectors++;
        if ({act_a.rs, act_a.rt, act_a.rd, act_a.rsv, act_a.rtv, act_a.rdv} !== {5'd1, 5'd2, 5'd3, 3'b111}) begin
            miscompares++;
            $display("FAIL addu_regs: got rs=%0d rt=%0d rd=%0d v=%b%b%b want 1 2 3 111",
                     act_a.rs, act_a.rt, act_a.rd, act_a.rsv, act_a.rtv, act_a.rdv);
        end
        vectors++;
        if (act_a.funct !== 6'h21 || act_a.imm !== 32'h0 || act_a.ill !== 1'b0) begin
            miscompares++;
            $display("FAIL addu_funct: got funct=%h imm=%h ill=%b want 21 0 0", act_a.funct, act_a.imm, act_a.ill);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3] = '{32'h34051234, 32'h3C018000, 32'h8FA4FFFC};
        logic [13:0] eop [3] = '{14'h0002, 14'h0004, 14'h0008};
        logic [31:0] eimm[3] = '{32'h00001234, 32'h80000000, 32'hFFFFFFFC};
        logic [14:0] eregs[3] = '{{5'd0, 5'd5, 5'd0}, {5'd0, 5'd1, 5'd0}, {5'd29, 5'd4, 5'd0}};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1, ins[i], 32'h200 + 32'(4 * i), 1, 0);
            else drive(0, 0, 0, 1, 0);
            tick();
            if (i >= 1 && i <= 3) begin
                vectors++;
                if (out_valid_a !== 1'b1 || act_a.pc !== 32'h200 + 32'(4 * (i - 1)) || act_a.op !== eop[i-1]
                    || act_a.imm !== eimm[i-1] || {act_a.rs, act_a.rt, act_a.rd} !== eregs[i-1]) begin
                    miscompares++;
                    $display("FAIL b2b_rec%0d: got vld=%b pc=%h op=%h imm=%h rs=%0d rt=%0d want pc=%h op=%h imm=%h",
                             i - 1, out_valid_a, act_a.pc, act_a.op, act_a.imm, act_a.rs, act_a.rt,
                             32'h200 + 32'(4 * (i - 1)), eop[i-1], eimm[i-1]);
                end
            end
            if (i == 2) begin
                vectors++;
                if (act_a.rsv !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lui_rs_valid: got %b want 0", act_a.rsv);
                end
            end
        end
        vectors++;
        if (out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid_a);
        end
    endtask

    task automatic test_ext_ops();
        drive(1, 32'h14220003, 32'h300, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        tick();
        vectors++;
        if (out_valid_a !== 1'b1 || act_a.op !== 14'h0800 || act_a.imm !== 32'h3 || act_a.ill !== 1'b0
            || act_a.rs !== 5'd1 || act_a.rt !== 5'd2) begin
            miscompares++;
            $display("FAIL bne_ext1: got vld=%b op=%h imm=%h ill=%b want 1 0800 00000003 0",
                     out_valid_a, act_a.op, act_a.imm, act_a.ill);
        end
        vectors++;
        if (out_valid_b !== 1'b1 || act_b !== rec_t'({32'h300, 96'h0, 1'b1})) begin
            miscompares++;
            $display("FAIL bne_ext0: got vld=%b op=%h rs=%0d rt=%0d ill=%b pc=%h want illegal record at 300",
                     out_valid_b, act_b.op, act_b.rs, act_b.rt, act_b.ill, act_b.pc);
        end
        tick();
    endtask

    task automatic test_full();
        int acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h00221821, 32'h400 + 32'(4 * i), 0, 0);
            #1;
            if (in_ready_a) acc++;
            tick();
        end
        vectors++;
        if (acc != 5 || count_a !== 3'd4 || in_ready_a !== 1'b0) begin
            miscompares++;
            $display("FAIL full: got accepted=%0d count=%0d in_ready=%b want 5 4 0", acc, count_a, in_ready_a);
        end
        drive(0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_valid_a !== 1'b1 || act_a.pc !== 32'h400 + 32'(4 * k) || count_a !== 3'(4 - k)) begin
                miscompares++;
                $display("FAIL drain%0d: got vld=%b pc=%h count=%0d want 1 %h %0d",
                         k, out_valid_a, act_a.pc, count_a, 32'h400 + 32'(4 * k), 4 - k);
            end
            if (k == 1) begin
                vectors++;
                if (in_ready_a !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_after_pop: got %b want 1", in_ready_a);
                end
            end
            tick();
        end
        vectors++;
        if (out_valid_a !== 1'b0 || count_a !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_end: got vld=%b count=%0d want 0 0", out_valid_a, count_a);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h34051234, 32'h500 + 32'(4 * i), 0, 0);
            tick();
        end
        vectors++;
        if (count_a !== 3'd3 || out_valid_a !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_setup: got count=%0d vld=%b want 3 1", count_a, out_valid_a);
        end
        drive(1, 32'h3C018000, 32'h5F0, 0, 1);
        #1;
        vectors++;
        if (in_ready_a !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: got in_ready=%b want 0", in_ready_a);
        end
        tick();
        drive(0, 0, 0, 1, 0);
        vectors++;
        if (count_a !== 3'd0 || out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: got count=%0d vld=%b want 0 0", count_a, out_valid_a);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (out_valid_a !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_leak: got out_valid=1 pc=%h want no record", act_a.pc);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h8FA4FFFC, 32'h600 + 32'(4 * i), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (count_a !== 3'd2 || out_valid_a !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_setup: got count=%0d vld=%b want 2 1", count_a, out_valid_a);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (count_a !== 3'd0 || out_valid_a !== 1'b0 || act_a !== '0) begin
            miscompares++;
            $display("FAIL arst_clear: got count=%0d vld=%b rec=%h want all 0", count_a, out_valid_a, act_a);
        end
        mq.delete();
        m_vld = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] pool [16] = '{32'h00221821, 32'h00221823, 32'h03E00008, 32'h0000000C,
                                   32'h0022182A, 32'h0040F809, 32'h34051234, 32'h3C018000,
                                   32'h8FA4FFFC, 32'hAFA4FFF0, 32'h1022FFFE, 32'h14220003,
                                   32'h2402FFFF, 32'h08000040, 32'h0C100000, 32'h00000000};
        logic [31:0] w;
        rec_t ea, eb;
        bit   erdy;
        for (int i = 0; i < 600; i++) begin
            w = ($urandom_range(0, 4) == 0) ? $urandom() : pool[$urandom_range(0, 15)];
            drive($urandom_range(0, 3) != 0, w, $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
            #1;
            erdy = (mq.size() < DEPTH) && !flush;
            vectors++;
            if (in_ready_a !== erdy || in_ready_b !== erdy) begin
                miscompares++;
                $display("FAIL rnd_in_ready@%0d: got %b/%b want %b", i, in_ready_a, in_ready_b, erdy);
            end
            tick();
            vectors++;
            if (count_a !== 3'(mq.size()) || count_b !== 3'(mq.size())
                || out_valid_a !== m_vld || out_valid_b !== m_vld) begin
                miscompares++;
                $display("FAIL rnd_state@%0d: got cnt=%0d/%0d vld=%b/%b want cnt=%0d vld=%b",
                         i, count_a, count_b, out_valid_a, out_valid_b, mq.size(), m_vld);
            end
            if (m_vld) begin
                ea = ref_decode(m_out[63:32], m_out[31:0], 1'b1);
                eb = ref_decode(m_out[63:32], m_out[31:0], 1'b0);
                vectors++;
                if (act_a !== ea || act_b !== eb) begin
                    miscompares++;
                    $display("FAIL rnd_rec@%0d instr=%h: got %h / %h want %h / %h",
                             i, m_out[31:0], act_a, act_b, ea, eb);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        m_vld = 1'b0;
        m_out = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        test_reset();
        test_addu();
        test_back_to_back();
        test_ext_ops();
        test_full();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary within 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, parametrised instruction decode stage for the niccore-mips32 front end. It accepts raw 32-bit instructions and their PCs from fetch through a valid/ready handshake and holds them in a DEPTH-entry FIFO. It decodes the FIFO head into a registered output record that issue/rename consumes through a second valid/ready handshake. It extends the base ISA with an optional instruction group, gates unused fields to zero rather than X, flags illegal encodings, and supports a synchronous pipeline flush.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- PC_W, 32: PC width.
- EXT_OPS, 1: 1 enables addiu, bne, slt, jalr; 0 decodes them as illegal.

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous flush; discards FIFO and output record.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  FIFO can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  decoded record valid.
- out_ready  in  1  consumer accepts record.
- out_pc  out  PC_W  PC of the record.
- out_op  out  14  one-hot op flags: [0] alu_r (addu/subu), [1] ori, [2] lui, [3] lw, [4] sw, [5] beq, [6] j, [7] jal, [8] jr, [9] syscall, [10] addiu, [11] bne, [12] slt, [13] jalr.
- out_rs, out_rt, out_rd  out  5 each  register indices; 0 when the matching valid bit is 0.
- out_rs_valid, out_rt_valid, out_rd_valid  out  1 each  field meaningful.
- out_funct  out  6  instr[5:0] for R-type, else 0.
- out_imm32  out  32  final immediate, see Operation.
- out_jtarget  out  26  instr[25:0] for j/jal, else 0.
- out_illegal  out  1  unrecognised encoding.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output record.

## Operation
- Decode table: R-type (opcode 0) with funct 0x21 addu, 0x23 subu, 0x08 jr, 0x0c syscall, 0x2a slt*, 0x09 jalr*. I/J-type opcodes: 0x0d ori, 0x0f lui, 0x23 lw, 0x2b sw, 0x04 beq, 0x05 bne*, 0x09 addiu*, 0x02 j, 0x03 jal. Entries marked * exist only when EXT_OPS=1.
- Field validity:
  - rs valid for alu_r, slt, jr, jalr, ori, lw, sw, beq, bne, addiu.
  - rt valid for alu_r, slt, ori, lw, sw, beq, bne, addiu, lui.
  - rd valid for alu_r, slt, jalr.
- out_imm32:
  - sign-extended imm16 for lw, sw, beq, bne, addiu.
  - zero-extended for ori.
  - {imm16, 16'h0} for lui.
  - 0 otherwise.
- Illegal encoding: out_op = 0, all field valid bits 0, all fields 0, out_illegal = 1. The record still flows through the handshake with its PC.
- FIFO push when in_valid && in_ready. in_ready = (count < DEPTH) && !flush, independent of out_ready.
- Output register loads the decoded FIFO head when the FIFO is non-empty and (!out_valid || out_ready). That load pops the FIFO. Push and pop in the same cycle leave count unchanged.
- Output record is stable while out_valid && !out_ready.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Flush takes priority over push, pop and load. On the next edge count = 0, out_valid = 0, and pointers are zeroed. in_valid during flush is dropped.

## Timing
- Reset values: out_valid = 0, count = 0, pointers = 0, every output field = 0, out_illegal = 0. in_ready = 1 once rst_n is high.
- Latency: instruction accepted at edge N is written to the FIFO. The output record loads at edge N+1, so out_valid is high after N+1. No bypass path.
- Throughput: one instruction per cycle sustained with out_ready held high.
- Full: count = DEPTH forces in_ready low that cycle. in_ready rises the cycle after a pop.
- Back-pressure: out_ready low holds the record. The FIFO keeps filling up to DEPTH.
- Reset asserted mid-stream clears all state immediately. No record survives.

## Test plan
- After reset, push addu $3,$1,$2 (0x00221821, pc 0x100) with out_ready=1 -> two edges later: out_valid, out_op=0x0001, rs=1, rt=2, rd=3, all three valid bits 1, out_funct=0x21, out_imm32=0, out_pc=0x100.
- Push back-to-back:
  - ori $5,$0,0x1234 (0x34051234) -> out_op bit1, rt=5, imm32=0x00001234.
  - lui $1,0x8000 (0x3C018000) -> imm32=0x80000000, rs_valid=0.
  - lw $4,-4($29) (0x8FA4FFFC) -> rs=29, rt=4, imm32=0xFFFFFFFC.
  - Expected: three records on consecutive cycles, in order.
- EXT_OPS=0, push bne (0x14220003) -> out_illegal=1, out_op=0, rs=rt=0. With EXT_OPS=1 the same word -> out_op bit11, imm32=0x00000003.
- DEPTH=4, out_ready=0, push 6 instructions -> in_ready drops after 4 FIFO pushes plus 1 output load, count=4. Raise out_ready -> all 5 accepted records emerge in order, one per cycle, and count returns to 0.
- With count=3 and out_valid=1, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, and the flush-cycle instruction never appears.
- Drop rst_n asynchronously mid-stream (count=2) -> out_valid and count go to 0 before the next clock edge.
